// File: rtl/cpu_pkg.sv
// Shared CPU-side typedefs: bus word type, register-bus operation codes and
// the register-bus sequencer states.
package cpu_pkg;

  localparam int BUS_W = 8;

  typedef logic [BUS_W-1:0] bus_word_t;

  typedef enum logic [1:0] {
    RB_MOV  = 2'd0,
    RB_LOAD = 2'd1,
    RB_CLR  = 2'd2,
    RB_SWAP = 2'd3
  } enum_rb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SWP_A = 3'd2,
    ST_SWP_B = 3'd3,
    ST_SWP_C = 3'd4
  } enum_rb_state_t;

endpackage

// File: rtl/common_reg.sv
// Generic enabled register with asynchronous active-low clear.
module common_reg #(
  parameter int pDATA_WIDTH = 8
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   iwe,
  input  logic [pDATA_WIDTH-1:0] id,
  output logic [pDATA_WIDTH-1:0] oq
);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oq <= '0;
    end else if (iwe) begin
      oq <= id;
    end
  end

endmodule

// File: rtl/cpu_reg_bus.sv
// Register file on a single shared bus: MOV/LOAD/CLR in one bus cycle,
// SWAP in three bus cycles through a temporary register.
module cpu_reg_bus
  import cpu_pkg::*;
#(
  parameter int pDATA_WIDTH = 8,
  parameter int pREG_NO     = 4,
  parameter int pIDX_W      = $clog2(pREG_NO)
) (
  input  logic                           iclk,
  input  logic                           irst_n,
  input  logic                           ien,
  input  logic                           ireq_valid,
  output logic                           oreq_ready,
  input  logic [1:0]                     iop,
  input  logic [pIDX_W-1:0]              isrc_idx,
  input  logic [pIDX_W-1:0]              idst_idx,
  input  logic [pDATA_WIDTH-1:0]         iext_data,
  output logic [pDATA_WIDTH-1:0]         obus,
  output logic [pREG_NO*pDATA_WIDTH-1:0] oreg_data,
  output logic                           obusy,
  output logic                           odone,
  output logic                           oerr,
  output logic [2:0]                     odbg_state
);

  localparam logic [pIDX_W:0] REG_BOUND = (pIDX_W+1)'(pREG_NO);

  enum_rb_state_t         state_q, state_d;
  enum_rb_op_t            op_q;
  logic [pIDX_W-1:0]      src_q, dst_q;
  logic [pDATA_WIDTH-1:0] ext_q, tmp_q;
  logic [pDATA_WIDTH-1:0] regs [pREG_NO];
  logic [pREG_NO-1:0]     reg_we;
  logic                   accept, idx_bad, done_d;

  // Handshake: a request transfers on a rising edge where ien, ireq_valid
  // and oreq_ready are all 1; ready is high only while IDLE.
  assign oreq_ready = (state_q == ST_IDLE);
  assign obusy      = ~oreq_ready;
  assign accept     = ien & ireq_valid & oreq_ready;
  assign idx_bad    = ({1'b0, isrc_idx} >= REG_BOUND) | ({1'b0, idst_idx} >= REG_BOUND);
  assign odbg_state = state_q;

  always_comb begin
    state_d = state_q;
    obus    = '0;
    reg_we  = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && !idx_bad) begin
          state_d = (iop == RB_SWAP) ? ST_SWP_A : ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          RB_MOV:  obus = regs[src_q];
          RB_LOAD: obus = ext_q;
          default: obus = '0;
        endcase
        reg_we[dst_q] = 1'b1;
        done_d        = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_SWP_A: begin
        obus    = regs[src_q];
        state_d = ST_SWP_B;
      end
      ST_SWP_B: begin
        obus          = regs[dst_q];
        reg_we[src_q] = 1'b1;
        state_d       = ST_SWP_C;
      end
      ST_SWP_C: begin
        obus          = tmp_q;
        reg_we[dst_q] = 1'b1;
        done_d        = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A disabled cycle must not write, so the bus value is simply held.
    if (!ien) begin
      reg_we = '0;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_IDLE;
      op_q    <= RB_MOV;
      src_q   <= '0;
      dst_q   <= '0;
      ext_q   <= '0;
      tmp_q   <= '0;
      odone   <= 1'b0;
      oerr    <= 1'b0;
    end else if (ien) begin
      state_q <= state_d;
      odone   <= done_d;
      oerr    <= accept & idx_bad;
      if (accept) begin
        op_q  <= enum_rb_op_t'(iop);
        src_q <= isrc_idx;
        dst_q <= idst_idx;
        ext_q <= iext_data;
      end
      if (state_q == ST_SWP_A) begin
        tmp_q <= obus;
      end
    end
  end

  for (genvar i = 0; i < pREG_NO; i++) begin : g_reg
    common_reg #(.pDATA_WIDTH(pDATA_WIDTH)) u_reg (
      .iclk  (iclk),
      .irst_n(irst_n),
      .iwe   (reg_we[i]),
      .id    (obus),
      .oq    (regs[i])
    );
    assign oreg_data[i*pDATA_WIDTH +: pDATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_cpu_reg_bus.sv
// Bench for cpu_reg_bus with five registers so out-of-range indices exist.
module tb_cpu_reg_bus;
  import cpu_pkg::*;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic iclk = 1'b0;
  logic irst_n, ien, ireq_valid, oreq_ready, obusy, odone, oerr;
  logic [1:0]     iop;
  logic [IW-1:0]  isrc_idx, idst_idx;
  logic [W-1:0]   iext_data, obus;
  logic [N*W-1:0] oreg_data;
  logic [2:0]     dbg_state;

  always #5 iclk = ~iclk;

  cpu_reg_bus #(.pDATA_WIDTH(W), .pREG_NO(N), .pIDX_W(IW)) dut (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .ien       (ien),
    .ireq_valid(ireq_valid),
    .oreq_ready(oreq_ready),
    .iop       (iop),
    .isrc_idx  (isrc_idx),
    .idst_idx  (idst_idx),
    .iext_data (iext_data),
    .obus      (obus),
    .oreg_data (oreg_data),
    .obusy     (obusy),
    .odone     (odone),
    .oerr      (oerr),
    .odbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic           err;
    logic [N*W-1:0] regs;
  } exp_t;

  exp_t         done_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model [N];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack_model();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = model[i];
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input int src, input int dst, input logic [W-1:0] ext);
    int   guard = 0;
    exp_t e;
    logic [W-1:0] t;
    ien        = 1'b1;
    ireq_valid = 1'b1;
    iop        = op;
    isrc_idx   = IW'(src);
    idst_idx   = IW'(dst);
    iext_data  = ext;
    while (!oreq_ready && guard <= 50) begin
      @(posedge iclk); #1;
      guard++;
    end
    if (guard > 50) check("ready_timeout", 64'd0, 64'd1);
    e.err = (src >= N) || (dst >= N);
    if (!e.err) begin
      case (op)
        2'd0: begin exp_q.push_back(model[src]); model[dst] = model[src]; end
        2'd1: begin exp_q.push_back(ext);        model[dst] = ext;        end
        2'd2: begin exp_q.push_back('0);         model[dst] = '0;         end
        default: begin
          exp_q.push_back(model[src]);
          exp_q.push_back(model[dst]);
          exp_q.push_back(model[src]);
          t = model[src]; model[src] = model[dst]; model[dst] = t;
        end
      endcase
    end
    e.regs = pack_model();
    done_q.push_back(e);
    @(posedge iclk); #1;
    ireq_valid = 1'b0;
  endtask

  task automatic wait_idle(input logic rand_en);
    int guard = 0;
    while (!oreq_ready && guard <= 50) begin
      ien = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge iclk); #1;
      guard++;
    end
    if (guard > 50) check("idle_timeout", 64'd0, 64'd1);
  endtask

  function automatic int rand_idx();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
  endfunction

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge iclk) begin
    if (irst_n) begin
      check("busy_vs_ready", 64'(obusy), 64'(!oreq_ready));
      if (oreq_ready) begin
        check("idle_bus", 64'(obus), 64'd0);
      end else if (exp_q.size() == 0) begin
        check("busy_without_op", 64'(obusy), 64'd0);
      end else begin
        check("bus", 64'(obus), 64'(exp_q[0]));
        if (ien) void'(exp_q.pop_front());
      end
      if (ien && (odone || oerr)) begin
        if (done_q.size() == 0) begin
          check("pulse_unexpected", 64'({odone, oerr}), 64'd0);
        end else begin
          mon_e = done_q.pop_front();
          check("done", 64'(odone), 64'(!mon_e.err));
          check("err", 64'(oerr), 64'(mon_e.err));
          check("regs", 64'(oreg_data), 64'(mon_e.regs));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    irst_n = 1'b0; ien = 1'b1; ireq_valid = 1'b0;
    iop = '0; isrc_idx = '0; idst_idx = '0; iext_data = '0;
    clear_model();
    repeat (2) @(posedge iclk);
    #1;
    check("rst_regs", 64'(oreg_data), 64'd0);
    check("rst_ready", 64'(oreq_ready), 64'd1);
    check("rst_busy", 64'(obusy), 64'd0);
    check("rst_done", 64'(odone), 64'd0);
    check("rst_err", 64'(oerr), 64'd0);
    check("rst_bus", 64'(obus), 64'd0);
    irst_n = 1'b1;
    @(posedge iclk); #1;

    // LOAD then MOV
    issue(RB_LOAD, 0, 2, 8'hA5);
    issue(RB_MOV, 2, 0, 8'h00);
    wait_idle(1'b0);
    check("mov_r0", 64'(oreg_data[0*W +: W]), 64'hA5);
    check("mov_r1", 64'(oreg_data[1*W +: W]), 64'h00);
    check("mov_r3", 64'(oreg_data[3*W +: W]), 64'h00);
    @(posedge iclk); #1;
    check("mov_done_one_cycle", 64'(odone), 64'd0);

    // SWAP r1/r3, bus sequence checked by the monitor
    issue(RB_LOAD, 0, 1, 8'h3C);
    issue(RB_LOAD, 0, 3, 8'hC3);
    issue(RB_SWAP, 1, 3, 8'h00);
    wait_idle(1'b0);
    check("swap_r1", 64'(oreg_data[1*W +: W]), 64'hC3);
    check("swap_r3", 64'(oreg_data[3*W +: W]), 64'h3C);

    // out-of-range destination
    issue(RB_MOV, 0, 6, 8'h00);
    check("oor_err", 64'(oerr), 64'd1);
    check("oor_done", 64'(odone), 64'd0);
    check("oor_ready", 64'(oreq_ready), 64'd1);
    @(posedge iclk); #1;
    check("oor_err_one_cycle", 64'(oerr), 64'd0);
    issue(RB_SWAP, 7, 1, 8'h00);
    wait_idle(1'b0);

    // SWAP with src == dst
    issue(RB_SWAP, 3, 3, 8'h00);
    wait_idle(1'b0);

    // freeze during SWP_B
    issue(RB_LOAD, 0, 0, 8'h5A);
    issue(RB_LOAD, 0, 1, 8'h96);
    issue(RB_SWAP, 0, 1, 8'h00);
    @(posedge iclk); #1;
    ien = 1'b0;
    repeat (3) begin
      check("frz_state", 64'(dbg_state), 64'(ST_SWP_B));
      check("frz_bus", 64'(obus), 64'h96);
      check("frz_done", 64'(odone), 64'd0);
      @(posedge iclk); #1;
    end
    ien = 1'b1;
    wait_idle(1'b0);
    check("frz_r0", 64'(oreg_data[0*W +: W]), 64'h96);
    check("frz_r1", 64'(oreg_data[1*W +: W]), 64'h5A);

    // reset during SWP_B
    issue(RB_LOAD, 0, 0, 8'h11);
    issue(RB_LOAD, 0, 2, 8'h22);
    issue(RB_SWAP, 0, 2, 8'h00);
    @(posedge iclk); #1;
    irst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    clear_model();
    #1;
    check("mid_rst_regs", 64'(oreg_data), 64'd0);
    check("mid_rst_ready", 64'(oreq_ready), 64'd1);
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_done", 64'(odone), 64'd0);
    @(posedge iclk); #1;
    irst_n = 1'b1;
    repeat (3) begin
      @(posedge iclk); #1;
      check("post_rst_done", 64'(odone), 64'd0);
    end

    // back-to-back LOAD then CLR on the done cycle
    issue(RB_LOAD, 0, 1, 8'h0F);
    @(posedge iclk); #1;
    check("b2b_done", 64'(odone), 64'd1);
    check("b2b_ready", 64'(oreq_ready), 64'd1);
    check("b2b_r1_load", 64'(oreg_data[1*W +: W]), 64'h0F);
    issue(RB_CLR, 0, 1, 8'h00);
    @(posedge iclk); #1;
    check("b2b_done2", 64'(odone), 64'd1);
    check("b2b_r1_clr", 64'(oreg_data[1*W +: W]), 64'h00);

    // randomized traffic with random enable gaps
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ien = ($urandom_range(0, 3) != 0);
        @(posedge iclk); #1;
      end
      issue(2'($urandom_range(0, 3)), rand_idx(), rand_idx(), 8'($urandom));
      wait_idle(1'b1);
    end

    ien = 1'b1;
    repeat (4) @(posedge iclk);
    #1;
    check("done_q_empty", 64'(done_q.size()), 64'd0);
    check("bus_q_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", n_miss);
    $fatal(1, "watchdog");
  end

endmodule
